// File: rtl/hdmi_scanout.sv
// rtl/hdmi_scanout.sv - video timing generator with VRAM scanout and aligned pixel pipeline
//
// Ports:
//   clk, rst_n           pixel clock, asynchronous active-low reset
//   enable               run scanout; 0 parks the raster at (0,0) with no reads
//   scale_mode[1:0]      0=1x 1=2x 2=4x 3=1x pixel replication (sampled at frame start)
//   base_addr[ADDR_W]    frame base word address (sampled at frame start)
//   vram_re/vram_addr    read strobe and address, driven in active-region cycles
//   vram_rdata[PIX_W]    read data, valid RD_LAT cycles after the strobe
//   pix_data/de          pixel and data enable, RD_LAT+1 cycles after the raster counters
//   hsync/vsync          syncs at HS_POL/VS_POL level, aligned with de
//   frame_start          one-cycle pulse on the first active pixel of each frame
//   h_pos/v_pos          raster position aligned with pix_data
//   tp_en                only with HDMI_SCANOUT_TESTPAT_EN: 8 vertical colour bars, no reads
module hdmi_scanout #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int ADDR_W   = 20,
    parameter int PIX_W    = 24,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        scale_mode,
    input  logic [ADDR_W-1:0] base_addr,
`ifdef HDMI_SCANOUT_TESTPAT_EN
    input  logic              tp_en,
`endif
    output logic              vram_re,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic [PIX_W-1:0]  vram_rdata,
    output logic [PIX_W-1:0]  pix_data,
    output logic              de,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start,
    output logic [11:0]       h_pos,
    output logic [11:0]       v_pos
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DEPTH   = RD_LAT + 1;

    localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
    localparam logic [11:0] H_LAST_C = 12'(H_TOTAL - 1);
    localparam logic [11:0] HS_BEG_C = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END_C = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_ACT_C  = 12'(V_ACTIVE);
    localparam logic [11:0] V_LAST_C = 12'(V_TOTAL - 1);
    localparam logic [11:0] VS_BEG_C = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END_C = 12'(V_ACTIVE + V_FP + V_SYNC);

    // Words per source line for each scale: the line-start register advances by these.
    localparam logic [ADDR_W-1:0] STEP1 = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] STEP2 = ADDR_W'(H_ACTIVE >> 1);
    localparam logic [ADDR_W-1:0] STEP4 = ADDR_W'(H_ACTIVE >> 2);

    logic              run_q, run_d;
    logic [11:0]       h_cnt_q, h_cnt_d;
    logic [11:0]       v_cnt_q, v_cnt_d;
    logic [1:0]        scale_q, scale_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [PIX_W-1:0]  pix_q, pix_d;

    logic              de_pipe_q   [DEPTH];
    logic              de_pipe_d   [DEPTH];
    logic              hs_pipe_q   [DEPTH];
    logic              hs_pipe_d   [DEPTH];
    logic              vs_pipe_q   [DEPTH];
    logic              vs_pipe_d   [DEPTH];
    logic              fs_pipe_q   [DEPTH];
    logic              fs_pipe_d   [DEPTH];
    logic [11:0]       hpos_pipe_q [DEPTH];
    logic [11:0]       hpos_pipe_d [DEPTH];
    logic [11:0]       vpos_pipe_q [DEPTH];
    logic [11:0]       vpos_pipe_d [DEPTH];

    logic              at_origin;
    logic [1:0]        scale_eff;
    logic [ADDR_W-1:0] line_base_eff;
    logic [1:0]        shift;
    logic [1:0]        vmask;
    logic [ADDR_W-1:0] step;
    logic              h_last;
    logic              v_last;
    logic              active;
    logic              read_ok;
    logic [ADDR_W-1:0] rd_addr;

`ifdef HDMI_SCANOUT_TESTPAT_EN
    localparam int          BAR_W      = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
    localparam logic [11:0] BAR_LAST_C = 12'(BAR_W - 1);

    logic [11:0] tp_px_q, tp_px_d;
    logic [2:0]  tp_bar_q, tp_bar_d;
    logic        tp_pipe_q  [RD_LAT];
    logic        tp_pipe_d  [RD_LAT];
    logic [2:0]  bar_pipe_q [RD_LAT];
    logic [2:0]  bar_pipe_d [RD_LAT];

    // White, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        return {{8{~idx[1]}}, {8{~idx[2]}}, {8{~idx[0]}}};
    endfunction
`endif

    always_comb begin
        // At (0,0) the frame settings come straight from the inputs so the very
        // first read of a frame already uses them; elsewhere the shadows rule.
        at_origin     = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
        scale_eff     = at_origin ? scale_mode : scale_q;
        line_base_eff = at_origin ? base_addr : line_base_q;

        case (scale_eff)
            2'd1: begin
                shift = 2'd1;
                vmask = 2'b01;
                step  = STEP2;
            end
            2'd2: begin
                shift = 2'd2;
                vmask = 2'b11;
                step  = STEP4;
            end
            default: begin
                shift = 2'd0;
                vmask = 2'b00;
                step  = STEP1;
            end
        endcase

        h_last = (h_cnt_q == H_LAST_C);
        v_last = (v_cnt_q == V_LAST_C);
        active = run_q && (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);

`ifdef HDMI_SCANOUT_TESTPAT_EN
        read_ok = ~tp_en;
`else
        read_ok = 1'b1;
`endif

        rd_addr   = line_base_eff + ADDR_W'(h_cnt_q >> shift);
        vram_re   = active && read_ok;
        vram_addr = vram_re ? rd_addr : '0;

        // Raster counters: parked at (0,0) unless running on consecutive cycles,
        // so a fresh enable always starts a frame from the top-left.
        run_d       = enable;
        scale_d     = scale_eff;
        line_base_d = line_base_eff;
        h_cnt_d     = 12'd0;
        v_cnt_d     = 12'd0;
        if (enable && run_q) begin
            if (h_last) begin
                v_cnt_d = v_last ? 12'd0 : (v_cnt_q + 12'd1);
                // Move to the next source line once every 2^shift output lines.
                if (!v_last && ((v_cnt_q[1:0] & vmask) == vmask)) begin
                    line_base_d = line_base_eff + step;
                end
            end else begin
                h_cnt_d = h_cnt_q + 12'd1;
                v_cnt_d = v_cnt_q;
            end
        end

        de_pipe_d[0]   = active;
        hs_pipe_d[0]   = (run_q && (h_cnt_q >= HS_BEG_C) && (h_cnt_q < HS_END_C)) ? HS_POL : ~HS_POL;
        vs_pipe_d[0]   = (run_q && (v_cnt_q >= VS_BEG_C) && (v_cnt_q < VS_END_C)) ? VS_POL : ~VS_POL;
        fs_pipe_d[0]   = run_q && at_origin;
        hpos_pipe_d[0] = h_cnt_q;
        vpos_pipe_d[0] = v_cnt_q;
        for (int i = 1; i < DEPTH; i++) begin
            de_pipe_d[i]   = de_pipe_q[i-1];
            hs_pipe_d[i]   = hs_pipe_q[i-1];
            vs_pipe_d[i]   = vs_pipe_q[i-1];
            fs_pipe_d[i]   = fs_pipe_q[i-1];
            hpos_pipe_d[i] = hpos_pipe_q[i-1];
            vpos_pipe_d[i] = vpos_pipe_q[i-1];
        end

        // Stage RD_LAT-1 is the cycle in which the read data for that pixel is
        // on vram_rdata; blanking forces zero so stale data never leaks out.
        pix_d = de_pipe_q[RD_LAT-1] ? vram_rdata : '0;

`ifdef HDMI_SCANOUT_TESTPAT_EN
        // Bar index tracked by counting pixels within a bar rather than dividing.
        tp_px_d  = tp_px_q;
        tp_bar_d = tp_bar_q;
        if (!run_q || h_last) begin
            tp_px_d  = 12'd0;
            tp_bar_d = 3'd0;
        end else if (active) begin
            if (tp_px_q == BAR_LAST_C) begin
                tp_px_d = 12'd0;
                if (tp_bar_q != 3'd7) begin
                    tp_bar_d = tp_bar_q + 3'd1;
                end
            end else begin
                tp_px_d = tp_px_q + 12'd1;
            end
        end

        tp_pipe_d[0]  = tp_en && active;
        bar_pipe_d[0] = tp_bar_q;
        for (int i = 1; i < RD_LAT; i++) begin
            tp_pipe_d[i]  = tp_pipe_q[i-1];
            bar_pipe_d[i] = bar_pipe_q[i-1];
        end
        if (tp_pipe_q[RD_LAT-1]) begin
            pix_d = PIX_W'(bar_colour(bar_pipe_q[RD_LAT-1]));
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= 1'b0;
            h_cnt_q     <= 12'd0;
            v_cnt_q     <= 12'd0;
            scale_q     <= 2'd0;
            line_base_q <= '0;
            pix_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                de_pipe_q[i]   <= 1'b0;
                hs_pipe_q[i]   <= ~HS_POL;
                vs_pipe_q[i]   <= ~VS_POL;
                fs_pipe_q[i]   <= 1'b0;
                hpos_pipe_q[i] <= 12'd0;
                vpos_pipe_q[i] <= 12'd0;
            end
`ifdef HDMI_SCANOUT_TESTPAT_EN
            tp_px_q  <= 12'd0;
            tp_bar_q <= 3'd0;
            for (int i = 0; i < RD_LAT; i++) begin
                tp_pipe_q[i]  <= 1'b0;
                bar_pipe_q[i] <= 3'd0;
            end
`endif
        end else begin
            run_q       <= run_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            scale_q     <= scale_d;
            line_base_q <= line_base_d;
            pix_q       <= pix_d;
            for (int i = 0; i < DEPTH; i++) begin
                de_pipe_q[i]   <= de_pipe_d[i];
                hs_pipe_q[i]   <= hs_pipe_d[i];
                vs_pipe_q[i]   <= vs_pipe_d[i];
                fs_pipe_q[i]   <= fs_pipe_d[i];
                hpos_pipe_q[i] <= hpos_pipe_d[i];
                vpos_pipe_q[i] <= vpos_pipe_d[i];
            end
`ifdef HDMI_SCANOUT_TESTPAT_EN
            tp_px_q  <= tp_px_d;
            tp_bar_q <= tp_bar_d;
            for (int i = 0; i < RD_LAT; i++) begin
                tp_pipe_q[i]  <= tp_pipe_d[i];
                bar_pipe_q[i] <= bar_pipe_d[i];
            end
`endif
        end
    end

    assign pix_data    = pix_q;
    assign de          = de_pipe_q[RD_LAT];
    assign hsync       = hs_pipe_q[RD_LAT];
    assign vsync       = vs_pipe_q[RD_LAT];
    assign frame_start = fs_pipe_q[RD_LAT];
    assign h_pos       = hpos_pipe_q[RD_LAT];
    assign v_pos       = vpos_pipe_q[RD_LAT];

endmodule

// File: doc/hdmi_scanout.md
HDMI_SCANOUT -- requirements
Module: hdmi_scanout

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, meaning active pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 110/40/220, meaning horizontal front porch, sync and back porch in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 720, meaning active lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 5/5/20, meaning vertical front porch, sync and back porch in lines.
REQ-005 SHALL have parameters HS_POL/VS_POL, default 1/1, meaning sync active level (1 = active-high).
REQ-006 SHALL have parameters ADDR_W 20 (VRAM address width), PIX_W 24 (pixel width) and RD_LAT 1 (VRAM read latency in cycles, 1..4).
REQ-007 SHALL have ports: clk in 1, pixel clock; rst_n in 1, reset; one clock; reset is asynchronous and active-low.
REQ-008 SHALL have ports: enable in 1, scanout run; scale_mode in 2, 0=1x 1=2x 2=4x 3=1x; base_addr in ADDR_W, frame base word address.
REQ-009 SHALL have ports: vram_re out 1, read strobe; vram_addr out ADDR_W, read address; vram_rdata in PIX_W, read data.
REQ-010 SHALL have ports: pix_data out PIX_W; de out 1; hsync out 1; vsync out 1; frame_start out 1, one-cycle pulse; h_pos out 12; v_pos out 12.

Function
REQ-011 SHALL count h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H params) and v_cnt 0..V_TOTAL-1, with v_cnt advancing when h_cnt wraps.
REQ-012 SHALL order each line and frame as active, front porch, sync, back porch; the active region is h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-013 SHALL assert vram_re exactly in active-region cycles and drive vram_addr = base + (v_cnt>>s)*(H_ACTIVE>>s) + (h_cnt>>s), where s = 0/1/2 for the scale mode.
REQ-014 SHALL compute the address incrementally from a line-start register; no multiplier is allowed.
REQ-015 SHALL sample scale_mode and base_addr into shadow registers only at h_cnt=0, v_cnt=0; mid-frame changes SHALL have no effect until the next frame.
REQ-016 SHALL register pix_data from vram_rdata RD_LAT cycles after the strobe, so total latency from counter to pix_data is RD_LAT+1.
REQ-017 SHALL delay de, hsync, vsync, h_pos and v_pos by RD_LAT+1 so they align with pix_data.
REQ-018 SHALL drive pix_data to 0 whenever the aligned de is 0.
REQ-019 SHALL assert hsync in the h sync window on every line and vsync in the v sync window for full lines, each at its POL level.
REQ-020 SHALL pulse frame_start for one cycle, aligned, at the first active pixel of each frame.
REQ-021 SHALL, when enable is 0, hold the counters at 0 with vram_re=0 and drive the outputs inactive after the pipeline drains; on enable rising it SHALL start at (0,0) and pulse frame_start.
REQ-022 SHALL keep the address arithmetic ADDR_W-bit modulo, wrapping silently at 2^ADDR_W.

Reset
REQ-023 SHALL, while rst_n=0, clear all counters, shadow registers and pipeline stages without waiting for a clock edge.
REQ-024 SHALL reset outputs to: pix_data 0, de 0, vram_re 0, vram_addr 0, frame_start 0, h_pos/v_pos 0, hsync = !HS_POL, vsync = !VS_POL.
REQ-025 SHALL, on reset mid-frame, discard in-flight reads and restart the frame from (0,0).

Configuration
REQ-026 SHALL compile in, when HDMI_SCANOUT_TESTPAT_EN is defined, an input tp_en (1 bit): tp_en=1 suppresses vram_re and drives 8 vertical colour bars of width H_ACTIVE/8 with the same latency and alignment.
REQ-027 SHALL, without HDMI_SCANOUT_TESTPAT_EN, have no tp_en port and no test-pattern logic.

Verification (H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, RD_LAT=1, base=0)
REQ-028 Bench SHALL check: enable=1, scale 1x, vram_rdata=addr -> pix_data 0..31 over 4 lines, de high 8 of every 14 cycles, 2-cycle latency.
REQ-029 Bench SHALL check: scale 2x -> lines 0-1 read addrs 0,0,1,1,2,2,3,3 and lines 2-3 read 4,4,5,5,6,6,7,7.
REQ-030 Bench SHALL check: timing -> hsync high at h_cnt 10-11, vsync high throughout v_cnt 5, frame_start once per 98 cycles.
REQ-031 Bench SHALL check: base_addr changed to 0x100 at mid-frame -> current frame unchanged, next frame first addr 0x100.
REQ-032 Bench SHALL check: rst_n pulsed low mid-line -> outputs reset values immediately; after release the next active pixel reads addr 0 with frame_start.
REQ-033 Bench SHALL check: with HDMI_SCANOUT_TESTPAT_EN and tp_en=1 -> vram_re stays 0 and each pixel shows its bar colour.
